// File: rtl/tictac_pkg.sv
// Shared tic-tac-toe codes, board-keeper state enum and the winning-line table.
// Latency: none (declarations only).
// Backpressure: not applicable.
package tictac_pkg;

  // Cell codes stored in each 2-bit board slot
  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] P1    = 2'b11;
  localparam logic [1:0] P2    = 2'b10;

  // Game result codes
  localparam logic [1:0] P1WIN = 2'b11;
  localparam logic [1:0] P2WIN = 2'b10;
  localparam logic [1:0] TIE   = 2'b01;
  localparam logic [1:0] NOWIN = 2'b00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    OVER = 2'd2
  } bkstate_t;

  // Nine 2-bit cells; cell i lives in bits [2i+1:2i] of the flat board
  typedef logic [8:0][1:0] board_t;

  // Winning lines in scan order: rows, columns, main diagonal, anti-diagonal
  localparam logic [0:7][0:2][3:0] LINE_TBL = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

  // True when no cell is left empty
  function automatic logic board_full(input board_t b);
    logic f;
    f = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (b[i] == EMPTY) f = 1'b0;
    end
    return f;
  endfunction

endpackage

// File: rtl/board_keeper_if.sv
// Move-address handshake between move sources (players, AI) and the board keeper.
// Latency: none (wiring only).
// Backpressure: source holds move_valid until it sees move_ready on a rising edge.
interface board_keeper_if;
  logic       move_valid;
  logic       move_ready;
  logic [3:0] move_addr;
  logic [1:0] move_cell;
  logic       move_ack;
  logic       move_err;

  modport master (
    output move_valid, move_addr, move_cell,
    input  move_ready, move_ack, move_err
  );

  modport slave (
    input  move_valid, move_addr, move_cell,
    output move_ready, move_ack, move_err
  );
endinterface

// File: rtl/line_match.sv
// Checks whether one winning line is fully owned by the given mover code.
// Latency: combinational.
// Backpressure: none.
module line_match
  import tictac_pkg::*;
(
  input  logic [17:0] gBoard,
  input  logic [2:0]  line,
  input  logic [1:0]  mover,
  output logic        match
);

  board_t cells;

  assign cells = gBoard;

  assign match = (cells[LINE_TBL[line][0]] == mover) &&
                 (cells[LINE_TBL[line][1]] == mover) &&
                 (cells[LINE_TBL[line][2]] == mover);

endmodule

// File: rtl/board_keeper.sv
// Board register and move arbiter: validates a move, writes it, scans 8 lines, publishes result.
// Latency: ack/err one cycle after handshake; result 1..8 edges after it (one line per cycle).
// Backpressure: move_ready low while scanning; optional turn check via BOARD_KEEPER_TURN_CHECK_EN.
module board_keeper
  import tictac_pkg::*;
#(
  parameter logic [3:0] BAD_ADDR = 4'b1111
) (
  input  logic               ph1,
  input  logic               reset,
  input  logic               new_game,
  board_keeper_if.slave      mv,
  output logic [17:0]        gBoard,
  output logic [1:0]         result,
  output logic [1:0]         turn
);

  bkstate_t   state, state_nx;
  logic [2:0] line_cnt, line_nx;
  logic [1:0] mover, mover_nx;
  board_t     board, board_nx;
  logic [1:0] result_nx, turn_nx;
  logic       ack_q, ack_nx;
  logic       err_q, err_nx;

  logic       take;
  logic       addr_ok;
  logic       code_ok;
  logic       turn_ok;
  logic [1:0] target;
  logic       legal;
  logic       match;

  assign gBoard        = board;
  assign mv.move_ready = (state != SCAN);
  assign mv.move_ack   = ack_q;
  assign mv.move_err   = err_q;
  assign take          = mv.move_valid && mv.move_ready;

  line_match u_line_match (
    .gBoard (board),
    .line   (line_cnt),
    .mover  (mover),
    .match  (match)
  );

  // Move legality: address in range, a real player code, empty target, game still open
  always_comb begin
    addr_ok = (mv.move_addr <= 4'd8) && (mv.move_addr != BAD_ADDR);
    code_ok = (mv.move_cell == P1) || (mv.move_cell == P2);
    target  = addr_ok ? board[mv.move_addr] : EMPTY;
`ifdef BOARD_KEEPER_TURN_CHECK_EN
    turn_ok = (mv.move_cell == turn);
`else
    turn_ok = 1'b1;
`endif
    legal   = addr_ok && code_ok && (target == EMPTY) && (state == IDLE) && turn_ok;
  end

  // Next-state logic: new_game clears everything and wins over a same-cycle handshake
  always_comb begin
    state_nx  = state;
    line_nx   = line_cnt;
    mover_nx  = mover;
    board_nx  = board;
    result_nx = result;
    turn_nx   = turn;
    ack_nx    = 1'b0;
    err_nx    = 1'b0;
    if (new_game) begin
      board_nx  = '0;
      result_nx = NOWIN;
      turn_nx   = P1;
      state_nx  = IDLE;
      line_nx   = 3'd0;
    end else begin
      case (state)
        IDLE, OVER: begin
          if (take) begin
            if (legal) begin
              board_nx[mv.move_addr] = mv.move_cell;
              mover_nx = mv.move_cell;
              line_nx  = 3'd0;
              ack_nx   = 1'b1;
              state_nx = SCAN;
            end else begin
              err_nx = 1'b1;
            end
          end
        end
        SCAN: begin
          if (match) begin
            result_nx = (mover == P1) ? P1WIN : P2WIN;
            state_nx  = OVER;
          end else if (line_cnt == 3'd7) begin
            if (board_full(board)) begin
              result_nx = TIE;
              state_nx  = OVER;
            end else begin
              turn_nx  = (turn == P1) ? P2 : P1;
              state_nx = IDLE;
            end
          end else begin
            line_nx = line_cnt + 3'd1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // State and output registers; reset aborts any scan in flight
  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      line_cnt <= 3'd0;
      mover    <= EMPTY;
      board    <= '0;
      result   <= NOWIN;
      turn     <= P1;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nx;
      line_cnt <= line_nx;
      mover    <= mover_nx;
      board    <= board_nx;
      result   <= result_nx;
      turn     <= turn_nx;
      ack_q    <= ack_nx;
      err_q    <= err_nx;
    end
  end

endmodule

// File: tb/tb_board_keeper.sv
// Self-checking bench for board_keeper: scoreboarded moves against a reference game model.
// Latency: checks ack/err one cycle after handshake and result timing per line scanned.
// Backpressure: waits (bounded) for move_ready before the next move; BOARD_KEEPER_TURN_CHECK_EN aware.
module tb_board_keeper;
  import tictac_pkg::*;

  logic        ph1;
  logic        reset;
  logic        new_game;
  logic [17:0] gBoard;
  logic [1:0]  result;
  logic [1:0]  turn;

  board_keeper_if bus ();

  board_keeper dut (
    .ph1      (ph1),
    .reset    (reset),
    .new_game (new_game),
    .mv       (bus.slave),
    .gBoard   (gBoard),
    .result   (result),
    .turn     (turn)
  );

  initial ph1 = 1'b0;
  always #5 ph1 = ~ph1;

  typedef struct {
    logic        ack;
    logic        err;
    logic [1:0]  res;
    int          lat;
    logic [17:0] brd;
    logic [1:0]  trn;
  } exp_t;

  exp_t sb[$];

  int errors = 0;
  int checks = 0;

  logic [1:0] m_board [9];
  logic [1:0] m_result;
  logic [1:0] m_turn;
  logic       m_over;

  int lt [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                    '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  function automatic logic [17:0] m_pack();
    return {m_board[8], m_board[7], m_board[6], m_board[5], m_board[4],
            m_board[3], m_board[2], m_board[1], m_board[0]};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 9; i++) m_board[i] = EMPTY;
    m_result = NOWIN;
    m_turn   = P1;
    m_over   = 1'b0;
  endtask

  // One move through the scoreboard: predict, drive, then compare handshake and scan outcome
  task automatic do_move(input logic [3:0] a, input logic [1:0] c, input string tag);
    exp_t e;
    logic ok;
    logic full;
    int   k;
    int   cnt;
    ok = 1'b0;
    if (a < 4'd9 && (c == P1 || c == P2) && !m_over) begin
      if (m_board[a] == EMPTY) ok = 1'b1;
`ifdef BOARD_KEEPER_TURN_CHECK_EN
      if (c != m_turn) ok = 1'b0;
`endif
    end
    e.ack = ok;
    e.err = !ok;
    e.lat = 0;
    if (ok) begin
      m_board[a] = c;
      k = -1;
      for (int l = 0; l < 8; l++) begin
        if (k < 0 && m_board[lt[l][0]] == c && m_board[lt[l][1]] == c && m_board[lt[l][2]] == c)
          k = l;
      end
      full = 1'b1;
      for (int i = 0; i < 9; i++) if (m_board[i] == EMPTY) full = 1'b0;
      if (k >= 0) begin
        m_result = c;
        m_over   = 1'b1;
        e.lat    = k + 1;
      end else if (full) begin
        m_result = TIE;
        m_over   = 1'b1;
        e.lat    = 8;
      end else begin
        m_turn = (m_turn == P1) ? P2 : P1;
        e.lat  = 8;
      end
    end
    e.res = m_result;
    e.brd = m_pack();
    e.trn = m_turn;
    sb.push_back(e);

    bus.move_addr  = a;
    bus.move_cell  = c;
    bus.move_valid = 1'b1;
    @(posedge ph1);
    #1;
    bus.move_valid = 1'b0;

    e = sb.pop_front();
    checks++;
    if (bus.move_ack !== e.ack) begin
      errors++;
      $display("FAIL %s ack: got %b want %b", tag, bus.move_ack, e.ack);
    end
    checks++;
    if (bus.move_err !== e.err) begin
      errors++;
      $display("FAIL %s err: got %b want %b", tag, bus.move_err, e.err);
    end
    if (e.ack) begin
      cnt = 0;
      while (bus.move_ready !== 1'b1 && cnt < 12) begin
        @(posedge ph1);
        #1;
        cnt++;
      end
      checks++;
      if (cnt != e.lat) begin
        errors++;
        $display("FAIL %s scan_edges: got %0d want %0d", tag, cnt, e.lat);
      end
    end
    checks++;
    if (result !== e.res) begin
      errors++;
      $display("FAIL %s result: got %b want %b", tag, result, e.res);
    end
    checks++;
    if (gBoard !== e.brd) begin
      errors++;
      $display("FAIL %s board: got %h want %h", tag, gBoard, e.brd);
    end
    checks++;
    if (turn !== e.trn) begin
      errors++;
      $display("FAIL %s turn: got %b want %b", tag, turn, e.trn);
    end
  endtask

  task automatic start_game();
    new_game = 1'b1;
    @(posedge ph1);
    #1;
    new_game = 1'b0;
    model_clear();
    checks++;
    if (gBoard !== 18'd0 || result !== NOWIN || turn !== P1 || bus.move_ready !== 1'b1) begin
      errors++;
      $display("FAIL new_game: got board=%h res=%b turn=%b rdy=%b want 0/00/11/1",
               gBoard, result, turn, bus.move_ready);
    end
  endtask

  task automatic test_reset();
    reset          = 1'b0;
    new_game       = 1'b0;
    bus.move_valid = 1'b0;
    bus.move_addr  = 4'd0;
    bus.move_cell  = EMPTY;
    repeat (3) @(posedge ph1);
    #1;
    checks++;
    if (gBoard !== 18'd0 || result !== NOWIN || turn !== P1) begin
      errors++;
      $display("FAIL reset_held: got board=%h res=%b turn=%b", gBoard, result, turn);
    end
    checks++;
    if (bus.move_ready !== 1'b1 || bus.move_ack !== 1'b0 || bus.move_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs: got rdy=%b ack=%b err=%b want 1/0/0",
               bus.move_ready, bus.move_ack, bus.move_err);
    end
    @(negedge ph1);
    reset = 1'b1;
    @(posedge ph1);
    #1;
    model_clear();
    checks++;
    if (gBoard !== 18'd0 || result !== NOWIN || turn !== P1 || bus.move_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: got board=%h res=%b turn=%b rdy=%b",
               gBoard, result, turn, bus.move_ready);
    end
  endtask

  task automatic test_row_win();
    start_game();
    do_move(4'd0, P1, "row_m1");
    do_move(4'd3, P2, "row_m2");
    do_move(4'd1, P1, "row_m3");
    do_move(4'd4, P2, "row_m4");
    do_move(4'd2, P1, "row_win");
    do_move(4'd5, P2, "row_after_over");
  endtask

  task automatic test_diag_win();
    start_game();
    do_move(4'd0, P1, "diag_m1");
    do_move(4'd2, P2, "diag_m2");
    do_move(4'd1, P1, "diag_m3");
    do_move(4'd4, P2, "diag_m4");
    do_move(4'd5, P1, "diag_m5");
    do_move(4'd6, P2, "diag_win");
  endtask

  task automatic test_tie();
    start_game();
    do_move(4'd0, P1, "tie_m1");
    do_move(4'd1, P2, "tie_m2");
    do_move(4'd2, P1, "tie_m3");
    do_move(4'd4, P2, "tie_m4");
    do_move(4'd3, P1, "tie_m5");
    do_move(4'd5, P2, "tie_m6");
    do_move(4'd7, P1, "tie_m7");
    do_move(4'd6, P2, "tie_m8");
    do_move(4'd8, P1, "tie_last");
    do_move(4'd8, P2, "tie_after_over");
  endtask

  task automatic test_rejects();
    start_game();
    do_move(4'd0, P1, "rej_setup");
    do_move(4'd15, P2, "rej_bad_addr");
    do_move(4'd9, P2, "rej_addr9");
    do_move(4'd0, P2, "rej_occupied");
    do_move(4'd1, 2'b01, "rej_code");
`ifdef BOARD_KEEPER_TURN_CHECK_EN
    do_move(4'd1, P1, "rej_turn");
`endif
    do_move(4'd1, P2, "rej_then_ok");
  endtask

  task automatic test_collision();
    start_game();
    bus.move_addr  = 4'd4;
    bus.move_cell  = P1;
    bus.move_valid = 1'b1;
    @(posedge ph1);
    #1;
    bus.move_valid = 1'b0;
    checks++;
    if (bus.move_ack !== 1'b1) begin
      errors++;
      $display("FAIL coll_first_ack: got %b want 1", bus.move_ack);
    end
    @(posedge ph1);
    #1;
    checks++;
    if (bus.move_ready !== 1'b0) begin
      errors++;
      $display("FAIL coll_scanning: ready got %b want 0", bus.move_ready);
    end
    new_game       = 1'b1;
    bus.move_addr  = 4'd5;
    bus.move_cell  = P2;
    bus.move_valid = 1'b1;
    @(posedge ph1);
    #1;
    new_game       = 1'b0;
    bus.move_valid = 1'b0;
    checks++;
    if (bus.move_ack !== 1'b0 || bus.move_err !== 1'b0) begin
      errors++;
      $display("FAIL coll_scan_hs: got ack=%b err=%b want 0/0", bus.move_ack, bus.move_err);
    end
    checks++;
    if (gBoard !== 18'd0 || turn !== P1 || result !== NOWIN || bus.move_ready !== 1'b1) begin
      errors++;
      $display("FAIL coll_scan_clear: got board=%h turn=%b res=%b rdy=%b",
               gBoard, turn, result, bus.move_ready);
    end
    new_game       = 1'b1;
    bus.move_addr  = 4'd0;
    bus.move_cell  = P1;
    bus.move_valid = 1'b1;
    @(posedge ph1);
    #1;
    new_game       = 1'b0;
    bus.move_valid = 1'b0;
    checks++;
    if (bus.move_ack !== 1'b0 || bus.move_err !== 1'b0 || gBoard !== 18'd0) begin
      errors++;
      $display("FAIL coll_idle: got ack=%b err=%b board=%h want 0/0/0",
               bus.move_ack, bus.move_err, gBoard);
    end
    model_clear();
  endtask

  task automatic test_mid_reset();
    start_game();
    bus.move_addr  = 4'd4;
    bus.move_cell  = P1;
    bus.move_valid = 1'b1;
    @(posedge ph1);
    #1;
    bus.move_valid = 1'b0;
    @(posedge ph1);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (gBoard !== 18'd0 || result !== NOWIN || turn !== P1) begin
      errors++;
      $display("FAIL midreset_state: got board=%h res=%b turn=%b", gBoard, result, turn);
    end
    checks++;
    if (bus.move_ready !== 1'b1 || bus.move_ack !== 1'b0 || bus.move_err !== 1'b0) begin
      errors++;
      $display("FAIL midreset_hs: got rdy=%b ack=%b err=%b want 1/0/0",
               bus.move_ready, bus.move_ack, bus.move_err);
    end
    @(negedge ph1);
    reset = 1'b1;
    model_clear();
    @(posedge ph1);
    #1;
    do_move(4'd8, P1, "post_reset_move");
  endtask

  initial begin
    test_reset();
    test_row_win();
    test_diag_win();
    test_tie();
    test_rejects();
    test_collision();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
